// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous single-port ROM
// (registered output, 1-cycle read latency) among NUM_REQ requesters.
// A grant in cycle N drives the ROM address at N+1 and returns the data
// with a one-hot rvalid strobe at N+2.
//
// Handshake (req/gnt): requester k asserts req_i[k] together with its address
// slice and holds both stable until it sees gnt_o[k]=1 in the same cycle; the
// transfer happens on that cycle's rising edge, after which the requester may
// change its address or drop req. Ungranted requests are never latched here,
// and rvalid_o/rdata_o carry no back-pressure (the requester must accept them).
module rom_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 5
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [ADDRESS_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]            rom_q_i,
  output logic                             busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer and the two-stage tag pipeline that follows each read.
  logic [PTR_W-1:0]         r_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rom_addr;
  logic                     r_s1_valid;
  logic [PTR_W-1:0]         r_s1_idx;
  logic [NUM_REQ-1:0]       r_rvalid;

  logic                     w_any;
  logic [PTR_W:0]           w_sum;
  logic [PTR_W-1:0]         w_idx;
  logic                     w_grant;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [PTR_W-1:0]         w_ptr_next;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [NUM_REQ-1:0]       w_s1_onehot;

  // Find the first requester at or after r_ptr, wrapping past the top index.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_any && req_i[w_sum[PTR_W-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  // Reset suppresses grants so nothing enters the pipeline while it clears.
  assign w_grant = w_any & ~reset_i;

  // One-hot grant decode and pointer advance past the winner.
  always_comb begin
    w_gnt = '0;
    if (w_grant) begin
      w_gnt[w_idx] = 1'b1;
    end
    w_ptr_next = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
  end

  // Address mux: pick the winner's slice out of the packed address bus.
  always_comb begin
    w_sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == PTR_W'(k)) begin
        w_sel_addr = addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  // Stage-1 tag decoded to one-hot so the stage-2 register is the strobe itself.
  always_comb begin
    w_s1_onehot = '0;
    if (r_s1_valid) begin
      w_s1_onehot[r_s1_idx] = 1'b1;
    end
  end

  // Grant registers the address and tag; the tag then follows the ROM latency.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_rvalid   <= '0;
    end else begin
      r_s1_valid <= w_grant;
      r_rvalid   <= w_s1_onehot;
      if (w_grant) begin
        r_rom_addr <= w_sel_addr;
        r_s1_idx   <= w_idx;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = rom_q_i;
  assign rom_addr_o = r_rom_addr;
  assign busy_o     = r_s1_valid | (|r_rvalid);

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed vector table with hand-computed
// expectations, a behavioural ROM (ROM[a] = 3*a mod 32), and an in-order
// response scoreboard built from the vectors' expected grants.
module tb_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 5;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_i;
  logic [NR-1:0]      req_i;
  logic [NR*AW-1:0]   addr_i;
  logic [NR-1:0]      gnt_o;
  logic [NR-1:0]      rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic [AW-1:0]      rom_addr_o;
  logic [DW-1:0]      rom_q;
  logic               busy_o;

  rom_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rom_addr_o (rom_addr_o),
    .rom_q_i    (rom_q),
    .busy_o     (busy_o)
  );

  // Behavioural synchronous ROM with registered output.
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  initial begin
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = DW'(a * 3);
  end
  always @(posedge clk) rom_q <= rom_mem[rom_addr_o];

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*AW-1:0] addr;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_rvalid;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_rom_addr;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];
  logic [NR+DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [NR*AW-1:0] pk(input logic [AW-1:0] a3, input logic [AW-1:0] a2,
                                          input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [NR-1:0] req, input logic [NR*AW-1:0] addr,
                              input logic [NR-1:0] e_gnt, input logic [NR-1:0] e_rvalid,
                              input logic [DW-1:0] e_rdata, input logic [AW-1:0] e_rom_addr,
                              input logic e_busy);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr;
    v.e_gnt = e_gnt; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
    v.e_rom_addr = e_rom_addr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: called just after a rising edge; drives the vector, checks at the
  // falling edge, updates the scoreboard, then moves to just after the next edge.
  task automatic apply(input vec_t v, input string tag);
    logic [NR+DW-1:0] e;
    reset_i = v.rst;
    req_i   = v.req;
    addr_i  = v.addr;
    @(negedge clk);
    check({tag, " gnt"},      32'(gnt_o),      32'(v.e_gnt));
    check({tag, " rvalid"},   32'(rvalid_o),   32'(v.e_rvalid));
    check({tag, " rom_addr"}, 32'(rom_addr_o), 32'(v.e_rom_addr));
    check({tag, " busy"},     32'(busy_o),     32'(v.e_busy));
    if (v.e_rvalid != '0) check({tag, " rdata"}, 32'(rdata_o), 32'(v.e_rdata));
    if (rvalid_o != '0) begin
      if (exp_q.size() == 0) begin
        check({tag, " sb_unexpected_rvalid"}, 32'(rvalid_o), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check({tag, " sb_order"}, 32'({rvalid_o, rdata_o}), 32'(e));
      end
    end
    if (v.rst) exp_q.delete();
    if (!v.rst && v.e_gnt != '0) begin
      for (int k = 0; k < NR; k++) begin
        if (v.e_gnt[k]) exp_q.push_back({v.e_gnt, rom_mem[v.addr[k*AW +: AW]]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: rst, req, addr, exp gnt, exp rvalid, exp rdata, exp rom_addr, exp busy.
    // Single read by requester 1 at address 7 (ROM[7]=0x15).
    vecs.push_back(mk(0, 4'b0010, pk(0,0,7,0), 4'b0010, 4'b0000, 5'd0,  5'd0, 0));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 5'd0,  5'd7, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0010, 5'h15, 5'd7, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 5'd0,  5'd7, 0));
    // Reset to bring the pointer back to 0.
    vecs.push_back(mk(1, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 5'd0,  5'd7, 0));
    // All four requesting, addr k = k+1: grants 0,1,2,3,0,1,2,3.
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0001, 4'b0000, 5'd0,  5'd0, 0));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0010, 4'b0000, 5'd0,  5'd1, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0100, 4'b0001, 5'd3,  5'd2, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b1000, 4'b0010, 5'd6,  5'd3, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0001, 4'b0100, 5'd9,  5'd4, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0010, 4'b1000, 5'd12, 5'd1, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b0100, 4'b0001, 5'd3,  5'd2, 1));
    vecs.push_back(mk(0, 4'b1111, pk(4,3,2,1), 4'b1000, 4'b0010, 5'd6,  5'd3, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0100, 5'd9,  5'd4, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b1000, 5'd12, 5'd4, 1));
    // Requester 2 alone, back-to-back, addresses 3..6.
    vecs.push_back(mk(0, 4'b0100, pk(0,3,0,0), 4'b0100, 4'b0000, 5'd0,  5'd4, 0));
    vecs.push_back(mk(0, 4'b0100, pk(0,4,0,0), 4'b0100, 4'b0000, 5'd0,  5'd3, 1));
    vecs.push_back(mk(0, 4'b0100, pk(0,5,0,0), 4'b0100, 4'b0100, 5'd9,  5'd4, 1));
    vecs.push_back(mk(0, 4'b0100, pk(0,6,0,0), 4'b0100, 4'b0100, 5'd12, 5'd5, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0100, 5'd15, 5'd6, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0100, 5'd18, 5'd6, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 5'd0,  5'd6, 0));
    // Grant to 1 leaves ptr=2; then 0011 wraps to 0, then 1.
    vecs.push_back(mk(0, 4'b0010, pk(0,0,10,0),  4'b0010, 4'b0000, 5'd0,  5'd6,  0));
    vecs.push_back(mk(0, 4'b0011, pk(0,0,12,11), 4'b0001, 4'b0000, 5'd0,  5'd10, 1));
    vecs.push_back(mk(0, 4'b0011, pk(0,0,12,11), 4'b0010, 4'b0010, 5'd30, 5'd11, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0001, 5'd1,  5'd12, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0010, 5'd4,  5'd12, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd12, 0));
    // Grant to 2 (ptr->3), reset next cycle with all requesting: no grant, read dropped,
    // then 1001 goes to 0 because the pointer restarted.
    vecs.push_back(mk(0, 4'b0100, pk(0,20,0,0),  4'b0100, 4'b0000, 5'd0,  5'd12, 0));
    vecs.push_back(mk(1, 4'b1111, pk(19,0,0,0),  4'b0000, 4'b0000, 5'd0,  5'd20, 1));
    vecs.push_back(mk(0, 4'b1001, pk(14,0,0,13), 4'b0001, 4'b0000, 5'd0,  5'd0,  0));
    vecs.push_back(mk(0, 4'b1000, pk(14,0,0,13), 4'b1000, 4'b0000, 5'd0,  5'd13, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0001, 5'd7,  5'd14, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b1000, 5'd10, 5'd14, 1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd14, 0));
    // Read of address 9, then 5 idle cycles: rom_addr holds at 9.
    vecs.push_back(mk(0, 4'b0001, pk(0,0,0,9),   4'b0001, 4'b0000, 5'd0,  5'd14, 0));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd9,  1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0001, 5'd27, 5'd9,  1));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd9,  0));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd9,  0));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0),   4'b0000, 4'b0000, 5'd0,  5'd9,  0));

    // Power-on reset; gnt must stay low even with every req set.
    reset_i = 1'b1;
    req_i   = '0;
    addr_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    req_i = 4'b1111;
    @(negedge clk);
    check("reset gnt",      32'(gnt_o),      32'(0));
    check("reset rvalid",   32'(rvalid_o),   32'(0));
    check("reset rom_addr", 32'(rom_addr_o), 32'(0));
    check("reset busy",     32'(busy_o),     32'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Hand-written: reset in the cycle after a grant (ptr=1 beforehand), with
    // requester 3 holding req through reset; it must win the first free cycle.
    apply(mk(0, 4'b0100, pk(0,17,0,0), 4'b0100, 4'b0000, 5'd0,  5'd9,  0), "h0");
    apply(mk(1, 4'b1000, pk(19,0,0,0), 4'b0000, 4'b0000, 5'd0,  5'd17, 1), "h1");
    apply(mk(0, 4'b1000, pk(19,0,0,0), 4'b1000, 4'b0000, 5'd0,  5'd0,  0), "h2");
    apply(mk(0, 4'b0000, pk(0,0,0,0),  4'b0000, 4'b0000, 5'd0,  5'd19, 1), "h3");
    apply(mk(0, 4'b0000, pk(0,0,0,0),  4'b0000, 4'b1000, 5'd25, 5'd19, 1), "h4");
    apply(mk(0, 4'b0000, pk(0,0,0,0),  4'b0000, 4'b0000, 5'd0,  5'd19, 0), "h5");

    // Hand-written: fairness with 1110 held from ptr=0 -> 1,2,3,1,2,3.
    for (int i = 0; i < 6; i++) begin
      reset_i = 1'b0;
      req_i   = 4'b1110;
      addr_i  = pk(3,2,1,0);
      @(negedge clk);
      check($sformatf("fair%0d gnt", i), 32'(gnt_o), 32'(4'b0010 << (i % 3)));
      @(posedge clk);
      #1;
    end
    req_i = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    check("final busy", 32'(busy_o), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
